// File: rtl/parking_input_conditioner.sv
// -----------------------------------------------------------------------------
// parking_input_conditioner
//
// Front end for parking_system. It cleans up the two raw car sensors and
// collects a two-digit keypad password.
//   - Each raw sensor goes through a two-flop synchronizer and then a
//     debouncer. The debounced output flips only after the synchronized input
//     has disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
//   - A three-state FSM (IDLE -> GOT1 -> READY) captures two 2-bit digits.
//     The pair is shown only in READY. READY lasts at most HOLD_CYCLES cycles
//     and ends early when the car leaves the entrance sensor.
//
// Parameters
//   DEBOUNCE_CYCLES  stable cycles needed to flip a debounced sensor (>= 2)
//   HOLD_CYCLES      cycle budget for the GOT1 wait and the READY hold (>= 2)
//
// Ports
//   clk                  system clock, rising edge
//   reset_n              asynchronous active-low reset
//   sensor_entrance_raw  raw entrance sensor (asynchronous to clk)
//   sensor_exit_raw      raw exit sensor (asynchronous to clk)
//   key_valid            one-cycle digit strobe from the keypad scanner
//   key_code[1:0]        digit value, sampled when key_valid = 1
//   key_clear            synchronous abort of password entry
//   sensor_entrance      debounced entrance sensor
//   sensor_exit          debounced exit sensor
//   password_1[1:0]      first digit, 0 outside READY
//   password_2[1:0]      second digit, 0 outside READY
//   pw_ready             high only while the pair is valid (READY)
// -----------------------------------------------------------------------------
module parking_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_CYCLES     = 64
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sensor_entrance_raw,
  input  logic       sensor_exit_raw,
  input  logic       key_valid,
  input  logic [1:0] key_code,
  input  logic       key_clear,
  output logic       sensor_entrance,
  output logic       sensor_exit,
  output logic [1:0] password_1,
  output logic [1:0] password_2,
  output logic       pw_ready
);

  localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int HOLD_W = $clog2(HOLD_CYCLES);

  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GOT1  = 2'd1,
    READY = 2'd2
  } state_t;

  // Bit 0 is the entrance sensor and bit 1 is the exit sensor.
  logic [1:0]       raw;
  logic [1:0]       sync_p0;
  logic [1:0]       sync_p1;
  logic [1:0]       deb;
  logic [1:0]       flip;
  logic [DEB_W-1:0] deb_cnt [2];

  logic             ent_fall;

  state_t            state, state_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;
  logic [1:0]        d1, d1_nxt;
  logic [1:0]        d2, d2_nxt;

  assign raw = {sensor_exit_raw, sensor_entrance_raw};

  // A sensor flips on the edge where its mismatch has lasted DEBOUNCE_CYCLES
  // cycles. The counter holds DEB_LAST during that final cycle.
  always_comb begin
    flip = '0;
    for (int i = 0; i < 2; i++) begin
      flip[i] = (sync_p1[i] != deb[i]) && (deb_cnt[i] == DEB_LAST);
    end
  end

  // ---- stage p0/p1: two-flop synchronizer, then debounce counters ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_p0    <= '0;
      sync_p1    <= '0;
      deb        <= '0;
      deb_cnt[0] <= '0;
      deb_cnt[1] <= '0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
      for (int i = 0; i < 2; i++) begin
        if (sync_p1[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (flip[i]) begin
          deb[i]     <= ~deb[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign sensor_entrance = deb[0];
  assign sensor_exit     = deb[1];

  // The entrance falling edge is taken from the flip condition itself. This
  // lets the FSM leave READY on the same edge that drops sensor_entrance, so
  // the password clears together with the sensor.
  assign ent_fall = deb[0] & flip[0];

  // Priority: key_clear > key_valid > entrance falling edge > counter expiry.
  always_comb begin
    state_nxt    = state;
    hold_cnt_nxt = hold_cnt;
    d1_nxt       = d1;
    d2_nxt       = d2;
    if (key_clear) begin
      state_nxt    = IDLE;
      hold_cnt_nxt = '0;
    end else if (key_valid) begin
      hold_cnt_nxt = HOLD_LOAD;
      if (state == GOT1) begin
        d2_nxt    = key_code;
        state_nxt = READY;
      end else begin
        // A digit in READY starts a new entry.
        d1_nxt    = key_code;
        state_nxt = GOT1;
      end
    end else begin
      unique case (state)
        GOT1: begin
          if (hold_cnt == '0) state_nxt = IDLE;
          else                hold_cnt_nxt = hold_cnt - 1'b1;
        end
        READY: begin
          if (ent_fall)            state_nxt = IDLE;
          else if (hold_cnt == '0) state_nxt = IDLE;
          else                     hold_cnt_nxt = hold_cnt - 1'b1;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // ---- stage p2: FSM registers and registered outputs ----
  // Outputs are decoded from the next state, so the pair appears on the same
  // edge that enters READY and never shows a half-entered pair.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      hold_cnt   <= '0;
      d1         <= '0;
      d2         <= '0;
      pw_ready   <= 1'b0;
      password_1 <= '0;
      password_2 <= '0;
    end else begin
      state      <= state_nxt;
      hold_cnt   <= hold_cnt_nxt;
      d1         <= d1_nxt;
      d2         <= d2_nxt;
      pw_ready   <= (state_nxt == READY);
      password_1 <= (state_nxt == READY) ? d1_nxt : 2'd0;
      password_2 <= (state_nxt == READY) ? d2_nxt : 2'd0;
    end
  end

endmodule

// File: tb/tb_parking_input_conditioner.sv
module tb_parking_input_conditioner;

  logic       clk;
  logic       reset_n;
  logic       sensor_entrance_raw;
  logic       sensor_exit_raw;
  logic       key_valid;
  logic [1:0] key_code;
  logic       key_clear;
  logic       sensor_entrance;
  logic       sensor_exit;
  logic [1:0] password_1;
  logic [1:0] password_2;
  logic       pw_ready;

  parking_input_conditioner #(
    .DEBOUNCE_CYCLES(16),
    .HOLD_CYCLES    (64)
  ) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .sensor_entrance_raw(sensor_entrance_raw),
    .sensor_exit_raw    (sensor_exit_raw),
    .key_valid          (key_valid),
    .key_code           (key_code),
    .key_clear          (key_clear),
    .sensor_entrance    (sensor_entrance),
    .sensor_exit        (sensor_exit),
    .password_1         (password_1),
    .password_2         (password_2),
    .pw_ready           (pw_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed vector: {sensor_entrance, sensor_exit, pw_ready, password_1, password_2}
  logic [6:0] obs;
  assign obs = {sensor_entrance, sensor_exit, pw_ready, password_1, password_2};

  typedef struct {
    string      tag;
    logic [6:0] v;
  } exp_t;

  exp_t sb [$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got={ent,exit,rdy,p1,p2}=%b want=%b at %0t", tag, got, want, $time);
    end
  endtask

  function automatic logic [6:0] ev(input logic se, input logic sx, input logic rdy,
                                    input logic [1:0] p1, input logic [1:0] p2);
    return {se, sx, rdy, p1, p2};
  endfunction

  // Let one rising edge pass with the current inputs and queue the outputs
  // expected after it. The monitor compares them on the following falling edge.
  task automatic cyc(input string tag, input logic [6:0] e);
    exp_t x;
    @(posedge clk);
    #1;
    x.tag = tag;
    x.v   = e;
    sb.push_back(x);
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t x;
      x = sb.pop_front();
      chk(x.tag, obs, x.v);
    end
  end

  initial begin
    reset_n             = 1'b0;
    sensor_entrance_raw = 1'b0;
    sensor_exit_raw     = 1'b0;
    key_valid           = 1'b0;
    key_code            = 2'd0;
    key_clear           = 1'b0;

    #12;
    chk("reset_state", obs, 7'd0);

    // Entrance sensor rises 18 edges after the raw change.
    @(negedge clk);
    reset_n             = 1'b1;
    sensor_entrance_raw = 1'b1;
    for (int i = 0; i < 17; i++) cyc("ent_rise_wait", ev(0, 0, 0, 2'd0, 2'd0));
    cyc("ent_rise", ev(1, 0, 0, 2'd0, 2'd0));

    // A 10-cycle glitch on the exit sensor is rejected.
    sensor_exit_raw = 1'b1;
    for (int i = 0; i < 10; i++) cyc("exit_glitch", ev(1, 0, 0, 2'd0, 2'd0));
    sensor_exit_raw = 1'b0;
    for (int i = 0; i < 20; i++) cyc("exit_settle", ev(1, 0, 0, 2'd0, 2'd0));

    // Pair 1,2 is held for exactly 64 cycles.
    key_valid = 1'b1;
    key_code  = 2'd1;
    cyc("key1", ev(1, 0, 0, 2'd0, 2'd0));
    key_code = 2'd2;
    cyc("key2", ev(1, 0, 1, 2'd1, 2'd2));
    key_valid = 1'b0;
    for (int i = 0; i < 63; i++) cyc("hold", ev(1, 0, 1, 2'd1, 2'd2));
    cyc("hold_expire", ev(1, 0, 0, 2'd0, 2'd0));
    for (int i = 0; i < 3; i++) cyc("idle", ev(1, 0, 0, 2'd0, 2'd0));

    // A single digit times out after 64 cycles. The next pair 2,1 must not
    // pick up the stale digit 3.
    key_valid = 1'b1;
    key_code  = 2'd3;
    cyc("lone_digit", ev(1, 0, 0, 2'd0, 2'd0));
    key_valid = 1'b0;
    for (int i = 0; i < 64; i++) cyc("got1_timeout", ev(1, 0, 0, 2'd0, 2'd0));
    key_valid = 1'b1;
    key_code  = 2'd2;
    cyc("after_to_1", ev(1, 0, 0, 2'd0, 2'd0));
    key_code = 2'd1;
    cyc("after_to_2", ev(1, 0, 1, 2'd2, 2'd1));
    key_valid = 1'b0;
    for (int i = 0; i < 5; i++) cyc("ready_2_1", ev(1, 0, 1, 2'd2, 2'd1));

    // The car leaves the entrance: the outputs clear together with the sensor.
    sensor_entrance_raw = 1'b0;
    for (int i = 0; i < 17; i++) cyc("leave_wait", ev(1, 0, 1, 2'd2, 2'd1));
    cyc("leave_clear", ev(0, 0, 0, 2'd0, 2'd0));
    cyc("leave_idle", ev(0, 0, 0, 2'd0, 2'd0));

    // key_clear together with key_valid in GOT1 discards the digit.
    key_valid = 1'b1;
    key_code  = 2'd3;
    cyc("clr_got1", ev(0, 0, 0, 2'd0, 2'd0));
    key_code  = 2'd1;
    key_clear = 1'b1;
    cyc("clr_and_key", ev(0, 0, 0, 2'd0, 2'd0));
    key_clear = 1'b0;
    key_code  = 2'd2;
    cyc("clr_next1", ev(0, 0, 0, 2'd0, 2'd0));
    key_code = 2'd0;
    cyc("clr_next2", ev(0, 0, 1, 2'd2, 2'd0));

    // A digit in READY starts a new entry. The outputs clear on that edge.
    key_code = 2'd1;
    cyc("renew_1", ev(0, 0, 0, 2'd0, 2'd0));
    key_code = 2'd3;
    cyc("renew_2", ev(0, 0, 1, 2'd1, 2'd3));
    key_valid = 1'b0;
    cyc("renew_hold", ev(0, 0, 1, 2'd1, 2'd3));

    // key_clear alone in READY.
    key_clear = 1'b1;
    cyc("clr_ready", ev(0, 0, 0, 2'd0, 2'd0));
    key_clear = 1'b0;
    cyc("clr_idle", ev(0, 0, 0, 2'd0, 2'd0));

    // Bring the entrance up again, enter a pair, then reset asynchronously.
    sensor_entrance_raw = 1'b1;
    for (int i = 0; i < 17; i++) cyc("ent2_wait", ev(0, 0, 0, 2'd0, 2'd0));
    cyc("ent2_rise", ev(1, 0, 0, 2'd0, 2'd0));
    key_valid = 1'b1;
    key_code  = 2'd3;
    cyc("ar_key1", ev(1, 0, 0, 2'd0, 2'd0));
    key_code = 2'd2;
    cyc("ar_key2", ev(1, 0, 1, 2'd3, 2'd2));
    key_valid = 1'b0;
    cyc("ar_ready", ev(1, 0, 1, 2'd3, 2'd2));
    #6;
    reset_n = 1'b0;
    #1;
    chk("async_reset", obs, 7'd0);
    sensor_entrance_raw = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) cyc("post_reset", ev(0, 0, 0, 2'd0, 2'd0));

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
